// File: rtl/sdram_read_prefetch.sv
// rtl/sdram_read_prefetch.sv - sequential single-byte SDRAM read prefetcher
// feeding a first-word-fall-through byte FIFO.
module sdram_read_prefetch #(
  parameter int ADDR_WIDTH = 25,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  abort,
  output logic                  running,
  output logic                  done,
  input  logic                  fifo_pop,
  output logic [7:0]            fifo_data,
  output logic                  fifo_empty,
  output logic [FIFO_AW:0]      fifo_count,
  output logic [ADDR_WIDTH-1:0] sd_rd_addr,
  output logic                  sd_rd_enable,
  input  logic [7:0]            sd_rd_data,
  input  logic                  sd_rd_ready,
  input  logic                  sd_ack
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_DATA = 3'd2;
  localparam logic [2:0] NEXT      = 3'd3;
  localparam logic [2:0] DRAIN     = 3'd4;

  localparam logic [FIFO_AW:0]      DEPTH    = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]      CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0]    PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [7:0]            mem [0:(2**FIFO_AW)-1];
  logic [FIFO_AW-1:0]    wr_ptr;
  logic [FIFO_AW-1:0]    rd_ptr;
  logic [FIFO_AW:0]      count;
  logic [FIFO_AW:0]      count_next;
  logic                  flush;
  logic                  push;
  logic                  pop_ok;
  logic                  ack_seen;

  assign flush    = (state == IDLE) && start;
  // A byte arriving together with abort is dropped rather than buffered.
  assign push     = (state == WAIT_DATA) && sd_rd_ready && !abort;
  assign pop_ok   = fifo_pop && (count != '0);
  assign ack_seen = (state == ISSUE) && sd_rd_enable && sd_ack;

  assign fifo_count = count;
  assign fifo_empty = (count == '0);
  assign fifo_data  = fifo_empty ? 8'h00 : mem[rd_ptr];
  assign sd_rd_addr = addr;

  always_comb begin
    count_next = count;
    if (flush)
      count_next = '0;
    else if (push && !pop_ok)
      count_next = count + CNT_ONE;
    else if (!push && pop_ok)
      count_next = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= sd_rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PTR_ONE;
        if (pop_ok)
          rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Request enable is raised on the edge that enters ISSUE, or later once a pop frees space.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr         <= '0;
      remaining    <= '0;
      running      <= 1'b0;
      done         <= 1'b0;
      sd_rd_enable <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              addr         <= start_addr;
              remaining    <= length;
              running      <= 1'b1;
              sd_rd_enable <= 1'b1;
              state        <= ISSUE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (ack_seen) begin
            sd_rd_enable <= 1'b0;
            state        <= abort ? DRAIN : WAIT_DATA;
          end else if (abort) begin
            sd_rd_enable <= 1'b0;
            running      <= 1'b0;
            state        <= IDLE;
          end else if (!sd_rd_enable && (count_next != DEPTH)) begin
            sd_rd_enable <= 1'b1;
          end
        end
        WAIT_DATA: begin
          if (abort) begin
            if (sd_rd_ready) begin
              running <= 1'b0;
              state   <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end else if (sd_rd_ready) begin
            addr      <= addr + ADDR_ONE;
            remaining <= remaining - LEN_ONE;
            state     <= NEXT;
          end
        end
        NEXT: begin
          if (remaining == '0) begin
            running <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end else if (abort) begin
            running <= 1'b0;
            state   <= IDLE;
          end else begin
            sd_rd_enable <= (count_next != DEPTH);
            state        <= ISSUE;
          end
        end
        DRAIN: begin
          if (sd_rd_ready) begin
            running <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          running      <= 1'b0;
          sd_rd_enable <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_read_prefetch.sv
// tb/tb_sdram_read_prefetch.sv - directed and randomized checks of the read
// prefetcher against a randomized-latency controller and an address-to-data model.
module tb_sdram_read_prefetch;

  localparam int AW  = 25;
  localparam int LW  = 16;
  localparam int FAW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [AW-1:0]  start_addr;
  logic [LW-1:0]  length;
  logic           abort;
  logic           running;
  logic           done;
  logic           fifo_pop;
  logic [7:0]     fifo_data;
  logic           fifo_empty;
  logic [FAW:0]   fifo_count;
  logic [AW-1:0]  sd_rd_addr;
  logic           sd_rd_enable;
  logic [7:0]     sd_rd_data;
  logic           sd_rd_ready;
  logic           sd_ack;

  always #5 clk = ~clk;

  sdram_read_prefetch #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_AW(FAW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .length(length), .abort(abort), .running(running), .done(done),
    .fifo_pop(fifo_pop), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .sd_rd_addr(sd_rd_addr), .sd_rd_enable(sd_rd_enable),
    .sd_rd_data(sd_rd_data), .sd_rd_ready(sd_rd_ready), .sd_ack(sd_ack)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int en_cycles = 0;
  logic [AW-1:0] req_log [$];
  bit hold_ack = 1'b0;
  bit hold_rdy = 1'b0;
  int ack_max = 2;
  int rdy_max = 2;

  // SDRAM contents as seen by the bench: each byte is derived from its address.
  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    return a[7:0] + 8'hA0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (sd_rd_enable === 1'b1) en_cycles++;
  end

  // Controller model: acks after a random delay, returns data after another.
  initial begin
    int ack_cnt;
    int rdy_cnt;
    bit pending;
    logic [AW-1:0] pa;
    sd_ack = 1'b0; sd_rd_ready = 1'b0; sd_rd_data = 8'h00;
    ack_cnt = 0; rdy_cnt = 0; pending = 1'b0; pa = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (rst_n !== 1'b1) begin
        sd_ack = 1'b0; sd_rd_ready = 1'b0; pending = 1'b0;
        continue;
      end
      #1;
      sd_ack = 1'b0;
      sd_rd_ready = 1'b0;
      if (rst_n !== 1'b1) begin
        pending = 1'b0;
      end else if (pending) begin
        if (!hold_rdy) begin
          if (rdy_cnt == 0) begin
            sd_rd_ready = 1'b1;
            sd_rd_data  = mem_byte(pa);
            pending     = 1'b0;
          end else begin
            rdy_cnt--;
          end
        end
      end else if (sd_rd_enable === 1'b1 && !hold_ack) begin
        if (ack_cnt == 0) begin
          sd_ack  = 1'b1;
          pa      = sd_rd_addr;
          req_log.push_back(sd_rd_addr);
          pending = 1'b1;
          rdy_cnt = $urandom_range(rdy_max, 0);
          ack_cnt = $urandom_range(ack_max, 0);
        end else begin
          ack_cnt--;
        end
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] a, input logic [LW-1:0] l);
    start = 1'b1; start_addr = a; length = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pop_expect(input logic [7:0] exp, input string tag);
    int k = 0;
    while (fifo_empty !== 1'b0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_avail"}, 32'(fifo_empty), 32'(0));
    chk(tag, 32'(fifo_data), 32'(exp));
    fifo_pop = 1'b1;
    @(negedge clk);
    fifo_pop = 1'b0;
  endtask

  task automatic wait_idle(input int exp_done, input string tag);
    for (int k = 0; k < 400; k++) begin
      if (running === 1'b0 && done_cnt >= exp_done) break;
      @(negedge clk);
    end
    chk({tag, "_running"}, 32'(running), 32'(0));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
  endtask

  task automatic check_reqs(input logic [AW-1:0] a, input int l, input string tag);
    logic [AW-1:0] ea;
    chk({tag, "_nreq"}, 32'(req_log.size()), 32'(l));
    for (int i = 0; i < l && i < req_log.size(); i++) begin
      ea = a + AW'(i);
      chk({tag, "_req_addr"}, 32'(req_log[i]), 32'(ea));
    end
  endtask

  task automatic run_xfer(input logic [AW-1:0] a, input int l, input string tag);
    int d0;
    logic [AW-1:0] ea;
    req_log.delete();
    d0 = done_cnt;
    do_start(a, LW'(l));
    chk({tag, "_run_lat"}, 32'(running), 32'(1));
    chk({tag, "_en_lat"}, 32'(sd_rd_enable), 32'(1));
    chk({tag, "_addr_lat"}, 32'(sd_rd_addr), 32'(a));
    for (int i = 0; i < l; i++) begin
      ea = a + AW'(i);
      pop_expect(mem_byte(ea), {tag, "_data"});
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
    wait_idle(d0 + 1, tag);
    check_reqs(a, l, tag);
    chk({tag, "_empty"}, 32'(fifo_empty), 32'(1));
  endtask

  initial begin
    int d0;
    int e0;
    int k;
    logic [AW-1:0] a;
    rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0;
    abort = 1'b0; fifo_pop = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_running", 32'(running), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_en", 32'(sd_rd_enable), 32'(0));
    chk("rst_addr", 32'(sd_rd_addr), 32'(0));
    chk("rst_count", 32'(fifo_count), 32'(0));
    chk("rst_empty", 32'(fifo_empty), 32'(1));
    chk("rst_data", 32'(fifo_data), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_xfer(25'h0000100, 4, "basic4");
    run_xfer(25'h1FFFFFE, 3, "wrap");
    chk("wrap_third_zero", 32'(req_log.size() > 2 ? req_log[2] : 25'h1), 32'(0));

    // FIFO-full stall: no pops until the buffer fills.
    a = 25'h0002000;
    req_log.delete();
    d0 = done_cnt;
    do_start(a, LW'(20));
    k = 0;
    while (fifo_count !== 5'd16 && k < 600) begin @(negedge clk); k++; end
    repeat (10) @(negedge clk);
    chk("stall_count", 32'(fifo_count), 32'(16));
    chk("stall_en", 32'(sd_rd_enable), 32'(0));
    chk("stall_nreq", 32'(req_log.size()), 32'(16));
    chk("stall_running", 32'(running), 32'(1));
    pop_expect(mem_byte(a), "stall_data");
    k = 0;
    while (req_log.size() < 17 && k < 50) begin @(negedge clk); k++; end
    chk("stall_resume", 32'(req_log.size()), 32'(17));
    for (int i = 1; i < 20; i++) pop_expect(mem_byte(a + AW'(i)), "stall_data");
    wait_idle(d0 + 1, "stall");
    check_reqs(a, 20, "stall");

    // Abort while the third byte is in flight.
    a = 25'h0003000;
    req_log.delete();
    d0 = done_cnt;
    do_start(a, LW'(5));
    k = 0;
    while (fifo_count !== 5'd2 && k < 200) begin @(negedge clk); k++; end
    hold_rdy = 1'b1;
    k = 0;
    while (req_log.size() < 3 && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_wait_running", 32'(running), 32'(1));
    hold_rdy = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_running", 32'(running), 32'(0));
    chk("abort_count", 32'(fifo_count), 32'(2));
    chk("abort_nreq", 32'(req_log.size()), 32'(3));
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    chk("abort_head", 32'(fifo_data), 32'(mem_byte(a)));

    // Zero length flushes the buffer and completes immediately.
    e0 = en_cycles;
    d0 = done_cnt;
    do_start(25'h0000040, '0);
    chk("zero_done", 32'(done), 32'(1));
    chk("zero_empty", 32'(fifo_empty), 32'(1));
    chk("zero_count", 32'(fifo_count), 32'(0));
    chk("zero_running", 32'(running), 32'(0));
    @(negedge clk);
    chk("zero_done_pulse", 32'(done), 32'(0));
    repeat (5) @(negedge clk);
    chk("zero_no_en", 32'(en_cycles), 32'(e0));
    chk("zero_done_cnt", 32'(done_cnt), 32'(d0 + 1));

    // Abort before ack.
    hold_ack = 1'b1;
    req_log.delete();
    do_start(25'h0004000, LW'(5));
    chk("abrt_ack_en_before", 32'(sd_rd_enable), 32'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abrt_ack_en_after", 32'(sd_rd_enable), 32'(0));
    chk("abrt_ack_running", 32'(running), 32'(0));
    hold_ack = 1'b0;
    repeat (5) @(negedge clk);
    chk("abrt_ack_nreq", 32'(req_log.size()), 32'(0));

    // Simultaneous push and pop keeps the count.
    a = 25'h0005000;
    req_log.delete();
    d0 = done_cnt;
    do_start(a, LW'(6));
    k = 0;
    while (!(sd_rd_ready === 1'b1 && fifo_count !== 5'd0) && k < 300) begin
      @(negedge clk); k++;
    end
    e0 = int'(fifo_count);
    chk("pp_head", 32'(fifo_data), 32'(mem_byte(a)));
    fifo_pop = 1'b1;
    @(negedge clk);
    fifo_pop = 1'b0;
    chk("pp_count", 32'(fifo_count), 32'(e0));
    for (int i = 1; i < 6; i++) pop_expect(mem_byte(a + AW'(i)), "pp_data");
    wait_idle(d0 + 1, "pp");

    // Asynchronous reset while a request is pending.
    a = 25'h0006000;
    do_start(a, LW'(6));
    k = 0;
    while (fifo_count !== 5'd2 && k < 200) begin @(negedge clk); k++; end
    hold_ack = 1'b1;
    k = 0;
    while (sd_rd_enable !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(sd_rd_enable), 32'(0));
    chk("arst_running", 32'(running), 32'(0));
    chk("arst_count", 32'(fifo_count), 32'(0));
    chk("arst_empty", 32'(fifo_empty), 32'(1));
    @(negedge clk);
    hold_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    run_xfer(25'h0007010, 5, "post_rst");

    for (int t = 0; t < 3; t++) begin
      ack_max = $urandom_range(3, 0);
      rdy_max = $urandom_range(4, 0);
      run_xfer(AW'($urandom), $urandom_range(30, 1), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
